pkt_meta_sched: RTL and testbench



---
 rtl/pkt_meta_sched_pkg.sv | 23 ++
 rtl/pkt_out_reg.sv | 73 +++++++
 rtl/pkt_meta_sched.sv | 183 ++++++++++++++++++
 tb/tb_pkt_meta_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_meta_sched_pkg.sv
// Shared definitions for the packet/metadata output scheduler.
//   - PKT_WIDTH      : width of one buffered packet beat (tag + payload)
//   - META_WIDTH_DEF : metadata word width shared with the parser layer
//   - TAG_*          : beat framing tags carried in beat bits [133:132]
//   - sched_state_e  : scheduler FSM states
package pkt_meta_sched_pkg;

    localparam int unsigned PKT_WIDTH      = 134;
    localparam int unsigned META_WIDTH_DEF = 128;

    localparam logic [1:0] TAG_MID    = 2'b00;
    localparam logic [1:0] TAG_HEAD   = 2'b01;
    localparam logic [1:0] TAG_TAIL   = 2'b10;
    localparam logic [1:0] TAG_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StFwd,
        StDrop,
        StResync
    } sched_state_e;

endpackage

// File: rtl/pkt_out_reg.sv
// Valid/ready egress register for the scheduler.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_load            : load a new beat (only honoured while o_adv = 1)
//   i_data            : beat to load
//   i_meta_load       : the loaded beat is a packet head; also load i_meta
//   i_meta            : metadata word for the head beat
//   i_out_ready       : downstream accepts the current beat
//   o_adv             : register may take a new beat this cycle
//   o_data_valid/o_data, o_meta_valid/o_meta : registered egress outputs
module pkt_out_reg #(
    parameter int unsigned DATA_WIDTH = 134,
    parameter int unsigned META_WIDTH = 128
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_meta_load,
    input  logic [META_WIDTH-1:0] i_meta,
    input  logic                  i_out_ready,
    output logic                  o_adv,
    output logic                  o_data_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_meta_valid,
    output logic [META_WIDTH-1:0] o_meta
);

    logic                  valid_q, valid_d;
    logic                  meta_valid_q, meta_valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [META_WIDTH-1:0] meta_q, meta_d;

    // Register is free when empty or its current beat is being taken.
    assign o_adv = !valid_q || i_out_ready;

    always_comb begin
        valid_d      = valid_q;
        meta_valid_d = meta_valid_q;
        data_d       = data_q;
        meta_d       = meta_q;
        if (o_adv) begin
            valid_d      = i_load;
            meta_valid_d = i_load && i_meta_load;
            if (i_load) begin
                data_d = i_data;
            end
            // o_meta keeps the packet's metadata through its body beats.
            if (i_load && i_meta_load) begin
                meta_d = i_meta;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q      <= 1'b0;
            meta_valid_q <= 1'b0;
            data_q       <= '0;
            meta_q       <= '0;
        end else begin
            valid_q      <= valid_d;
            meta_valid_q <= meta_valid_d;
            data_q       <= data_d;
            meta_q       <= meta_d;
        end
    end

    assign o_data_valid = valid_q;
    assign o_data       = data_q;
    assign o_meta_valid = meta_valid_q;
    assign o_meta       = meta_q;

endmodule

// File: rtl/pkt_meta_sched.sv
// Output scheduler: pairs each metadata word with its buffered packet and
// drains the packet to egress, dropping or resynchronising as needed.
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_pkt_empty/i_pkt_dout       : show-ahead packet FIFO head; o_pkt_rden pops
//   i_meta_empty/i_meta_dout     : show-ahead metadata FIFO head; o_meta_rden pops
//   o_data_valid/o_data          : egress beat, accepted when i_out_ready
//   o_meta_valid/o_meta          : metadata, flagged on the head beat only
//   o_fwd_cnt/o_drop_cnt/o_err_cnt : wrapping event counters
module pkt_meta_sched
    import pkt_meta_sched_pkg::*;
#(
    parameter int unsigned META_WIDTH = META_WIDTH_DEF,
    parameter int unsigned DROP_BIT   = 127,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_pkt_empty,
    input  logic [PKT_WIDTH-1:0]  i_pkt_dout,
    output logic                  o_pkt_rden,
    input  logic                  i_meta_empty,
    input  logic [META_WIDTH-1:0] i_meta_dout,
    output logic                  o_meta_rden,
    output logic                  o_data_valid,
    output logic [PKT_WIDTH-1:0]  o_data,
    output logic                  o_meta_valid,
    output logic [META_WIDTH-1:0] o_meta,
    input  logic                  i_out_ready,
    output logic [CNT_WIDTH-1:0]  o_fwd_cnt,
    output logic [CNT_WIDTH-1:0]  o_drop_cnt,
    output logic [CNT_WIDTH-1:0]  o_err_cnt
);

    sched_state_e state_q, state_d;

    logic [CNT_WIDTH-1:0] fwd_cnt_q, fwd_cnt_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    logic       adv;
    logic       pkt_rden, meta_rden;
    logic       load, meta_load;
    logic       fwd_inc, drop_inc, err_inc;
    logic [1:0] tag;
    logic       pkt_avail;

    assign tag       = i_pkt_dout[PKT_WIDTH-1 -: 2];
    assign pkt_avail = !i_pkt_empty;

    always_comb begin
        state_d   = state_q;
        pkt_rden  = 1'b0;
        meta_rden = 1'b0;
        load      = 1'b0;
        meta_load = 1'b0;
        fwd_inc   = 1'b0;
        drop_inc  = 1'b0;
        err_inc   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Meta is only consumed together with a head beat.
                if (!i_meta_empty && pkt_avail && adv) begin
                    unique case (tag)
                        TAG_HEAD, TAG_SINGLE: begin
                            meta_rden = 1'b1;
                            pkt_rden  = 1'b1;
                            if (i_meta_dout[DROP_BIT]) begin
                                drop_inc = 1'b1;
                                if (tag == TAG_HEAD) state_d = StDrop;
                            end else begin
                                load      = 1'b1;
                                meta_load = 1'b1;
                                fwd_inc   = 1'b1;
                                if (tag == TAG_HEAD) state_d = StFwd;
                            end
                        end
                        TAG_MID, TAG_TAIL: begin
                            pkt_rden = 1'b1;
                            err_inc  = 1'b1;
                            state_d  = StResync;
                        end
                        default: ;
                    endcase
                end
            end
            StFwd: begin
                if (pkt_avail && adv) begin
                    unique case (tag)
                        // Missing tail: leave the head for the next packet.
                        TAG_HEAD, TAG_SINGLE: begin
                            err_inc = 1'b1;
                            state_d = StIdle;
                        end
                        TAG_MID: begin
                            pkt_rden = 1'b1;
                            load     = 1'b1;
                        end
                        TAG_TAIL: begin
                            pkt_rden = 1'b1;
                            load     = 1'b1;
                            state_d  = StIdle;
                        end
                        default: ;
                    endcase
                end
            end
            StDrop: begin
                // Dropped beats never reach egress, so backpressure is ignored.
                if (pkt_avail) begin
                    unique case (tag)
                        TAG_HEAD, TAG_SINGLE: begin
                            err_inc = 1'b1;
                            state_d = StIdle;
                        end
                        TAG_MID: pkt_rden = 1'b1;
                        TAG_TAIL: begin
                            pkt_rden = 1'b1;
                            state_d  = StIdle;
                        end
                        default: ;
                    endcase
                end
            end
            StResync: begin
                if (pkt_avail) begin
                    if (tag == TAG_HEAD || tag == TAG_SINGLE) begin
                        state_d = StIdle;
                    end else begin
                        pkt_rden = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fwd_cnt_d  = fwd_cnt_q  + (fwd_inc  ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
        drop_cnt_d = drop_cnt_q + (drop_inc ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
        err_cnt_d  = err_cnt_q  + (err_inc  ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            fwd_cnt_q  <= '0;
            drop_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            fwd_cnt_q  <= fwd_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Pops are suppressed while reset is held so the FIFOs reset cleanly.
    assign o_pkt_rden  = pkt_rden && !i_rst;
    assign o_meta_rden = meta_rden && !i_rst;

    assign o_fwd_cnt  = fwd_cnt_q;
    assign o_drop_cnt = drop_cnt_q;
    assign o_err_cnt  = err_cnt_q;

    pkt_out_reg #(
        .DATA_WIDTH(PKT_WIDTH),
        .META_WIDTH(META_WIDTH)
    ) u_out_reg (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (load),
        .i_data      (i_pkt_dout),
        .i_meta_load (meta_load),
        .i_meta      (i_meta_dout),
        .i_out_ready (i_out_ready),
        .o_adv       (adv),
        .o_data_valid(o_data_valid),
        .o_data      (o_data),
        .o_meta_valid(o_meta_valid),
        .o_meta      (o_meta)
    );

endmodule

// File: tb/tb_pkt_meta_sched.sv
// Scoreboard bench for pkt_meta_sched: bench-side FIFO models feed the DUT,
// expected egress beats are queued when packets are pushed and compared when
// the DUT delivers them.
module tb_pkt_meta_sched;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_pkt_empty;
    logic [133:0] i_pkt_dout;
    logic         o_pkt_rden;
    logic         i_meta_empty;
    logic [127:0] i_meta_dout;
    logic         o_meta_rden;
    logic         o_data_valid;
    logic [133:0] o_data;
    logic         o_meta_valid;
    logic [127:0] o_meta;
    logic         i_out_ready;
    logic [31:0]  o_fwd_cnt;
    logic [31:0]  o_drop_cnt;
    logic [31:0]  o_err_cnt;

    always #5 i_clk = ~i_clk;

    pkt_meta_sched u_dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_pkt_empty (i_pkt_empty),
        .i_pkt_dout  (i_pkt_dout),
        .o_pkt_rden  (o_pkt_rden),
        .i_meta_empty(i_meta_empty),
        .i_meta_dout (i_meta_dout),
        .o_meta_rden (o_meta_rden),
        .o_data_valid(o_data_valid),
        .o_data      (o_data),
        .o_meta_valid(o_meta_valid),
        .o_meta      (o_meta),
        .i_out_ready (i_out_ready),
        .o_fwd_cnt   (o_fwd_cnt),
        .o_drop_cnt  (o_drop_cnt),
        .o_err_cnt   (o_err_cnt)
    );

    typedef struct {
        logic [133:0] d;
        logic         mv;
        logic [127:0] m;
    } exp_t;

    logic [133:0] pq[$];
    logic [127:0] mq[$];
    exp_t         eq[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pkt_pops, meta_pops, acc_cnt, mv_cnt, first_acc, last_acc;
    logic         prev_valid = 1'b0;
    logic         prev_ready = 1'b1;
    logic [133:0] prev_data = '0;
    logic [31:0]  f0, d0, e0;

    task automatic check(input string tag, input logic [133:0] act, input logic [133:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic upd_fifo();
        i_pkt_empty  = (pq.size() == 0);
        i_pkt_dout   = (pq.size() != 0) ? pq[0] : '0;
        i_meta_empty = (mq.size() == 0);
        i_meta_dout  = (mq.size() != 0) ? mq[0] : '0;
    endtask

    task automatic add_pkt(input logic [127:0] meta, input int n, input logic [15:0] id);
        for (int i = 0; i < n; i++) begin
            logic [1:0]   tg;
            logic [133:0] b;
            exp_t         e;
            tg = (n == 1) ? 2'b11 : (i == 0) ? 2'b01 : (i == n - 1) ? 2'b10 : 2'b00;
            b  = {tg, 100'd0, id, 16'(i)};
            pq.push_back(b);
            if (!meta[127]) begin
                e.d  = b;
                e.mv = (i == 0);
                e.m  = meta;
                eq.push_back(e);
            end
        end
        mq.push_back(meta);
        upd_fifo();
    endtask

    // One clock: compare at negedge, apply FIFO pops just after posedge.
    task automatic step();
        exp_t e;
        logic pop_p, pop_m;
        @(negedge i_clk);
        if (!i_rst) begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", {133'd0, o_data_valid}, 134'd1);
                check("hold_data", o_data, prev_data);
            end
            if (o_data_valid && i_out_ready) begin
                if (eq.size() == 0) begin
                    check("unexpected_beat", {133'd0, o_data_valid}, 134'd0);
                end else begin
                    e = eq.pop_front();
                    check("beat_data", o_data, e.d);
                    check("beat_meta_valid", {133'd0, o_meta_valid}, {133'd0, e.mv});
                    if (e.mv) check("beat_meta", {6'd0, o_meta}, {6'd0, e.m});
                    if (acc_cnt == 0) first_acc = cyc;
                    last_acc = cyc;
                    acc_cnt++;
                    if (o_meta_valid) mv_cnt++;
                end
            end
        end
        prev_valid = o_data_valid;
        prev_ready = i_out_ready;
        prev_data  = o_data;
        pop_p = o_pkt_rden;
        pop_m = o_meta_rden;
        @(posedge i_clk);
        #1;
        if (pop_p) begin
            if (pq.size() != 0) void'(pq.pop_front());
            pkt_pops++;
        end
        if (pop_m) begin
            if (mq.size() != 0) void'(mq.pop_front());
            meta_pops++;
        end
        upd_fifo();
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((pq.size() != 0 || eq.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_done", 134'(pq.size() + eq.size()), 134'd0);
        step();
        step();
    endtask

    task automatic start_test();
        pkt_pops  = 0;
        meta_pops = 0;
        acc_cnt   = 0;
        mv_cnt    = 0;
        f0 = o_fwd_cnt;
        d0 = o_drop_cnt;
        e0 = o_err_cnt;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got time limit expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        i_rst       = 1'b1;
        i_out_ready = 1'b1;
        upd_fifo();
        step();
        step();
        i_rst = 1'b0;
        check("rst_data_valid", {133'd0, o_data_valid}, 134'd0);
        check("rst_meta_valid", {133'd0, o_meta_valid}, 134'd0);
        check("rst_data", o_data, 134'd0);
        check("rst_fwd_cnt", {102'd0, o_fwd_cnt}, 134'd0);
        check("rst_err_cnt", {102'd0, o_err_cnt}, 134'd0);

        // 3-beat packet at full rate.
        start_test();
        add_pkt(128'h01, 3, 16'h0001);
        drain(40);
        check("t1_beats", 134'(acc_cnt), 134'd3);
        check("t1_consecutive", 134'(last_acc - first_acc), 134'd2);
        check("t1_meta_pulses", 134'(mv_cnt), 134'd1);
        check("t1_fwd_cnt", {102'd0, o_fwd_cnt - f0}, 134'd1);
        check("t1_meta_pops", 134'(meta_pops), 134'd1);
        check("t1_err_cnt", {102'd0, o_err_cnt - e0}, 134'd0);

        // Dropped 4-beat packet, then a normal packet.
        start_test();
        add_pkt({1'b1, 127'h5}, 4, 16'h0002);
        add_pkt(128'h22, 2, 16'h0003);
        drain(40);
        check("t2_drop_cnt", {102'd0, o_drop_cnt - d0}, 134'd1);
        check("t2_fwd_cnt", {102'd0, o_fwd_cnt - f0}, 134'd1);
        check("t2_pkt_pops", 134'(pkt_pops), 134'd6);
        check("t2_beats", 134'(acc_cnt), 134'd2);

        // Backpressure mid-packet.
        start_test();
        add_pkt(128'h44, 4, 16'h0004);
        step();
        step();
        i_out_ready = 1'b0;
        begin
            int p0;
            p0 = pkt_pops;
            repeat (5) step();
            check("t3_stall_no_pop", 134'(pkt_pops - p0), 134'd0);
        end
        i_out_ready = 1'b1;
        drain(40);
        check("t3_beats", 134'(acc_cnt), 134'd4);
        check("t3_pkt_pops", 134'(pkt_pops), 134'd4);

        // Single-beat packet followed by a 2-beat packet.
        start_test();
        add_pkt(128'h55, 1, 16'h0005);
        add_pkt(128'h66, 2, 16'h0006);
        drain(40);
        check("t4_beats", 134'(acc_cnt), 134'd3);
        check("t4_meta_pulses", 134'(mv_cnt), 134'd2);
        check("t4_fwd_cnt", {102'd0, o_fwd_cnt - f0}, 134'd2);

        // Stray middle beat ahead of a head.
        start_test();
        pq.push_back({2'b00, 116'd0, 16'hBAD});
        add_pkt(128'h99, 2, 16'h0007);
        drain(40);
        check("t5_err_cnt", {102'd0, o_err_cnt - e0}, 134'd1);
        check("t5_meta_pops", 134'(meta_pops), 134'd1);
        check("t5_fwd_cnt", {102'd0, o_fwd_cnt - f0}, 134'd1);
        check("t5_beats", 134'(acc_cnt), 134'd2);

        // Reset in the middle of forwarding.
        start_test();
        add_pkt(128'h77, 5, 16'h0008);
        repeat (3) step();
        i_rst = 1'b1;
        step();
        pq.delete();
        mq.delete();
        eq.delete();
        upd_fifo();
        i_rst      = 1'b0;
        prev_valid = 1'b0;
        check("t6_data_valid", {133'd0, o_data_valid}, 134'd0);
        check("t6_meta_valid", {133'd0, o_meta_valid}, 134'd0);
        check("t6_data", o_data, 134'd0);
        check("t6_meta", {6'd0, o_meta}, 134'd0);
        check("t6_fwd_cnt", {102'd0, o_fwd_cnt}, 134'd0);
        check("t6_drop_cnt", {102'd0, o_drop_cnt}, 134'd0);
        check("t6_err_cnt", {102'd0, o_err_cnt}, 134'd0);
        start_test();
        add_pkt(128'h88, 2, 16'h0009);
        drain(40);
        check("t6_after_fwd", {102'd0, o_fwd_cnt}, 134'd1);
        check("t6_after_beats", 134'(acc_cnt), 134'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
